// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement buffer with writeback capture, operand lookup and flush on mispredict
module reorder_buffer #(
   parameter int ROB_ENTRY_NUM   = 256,
   parameter int ROB_ENTRY_WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       alloc_valid,
   input  logic [4:0]                 alloc_rd,
   output logic                       alloc_ready,
   output logic [ROB_ENTRY_WIDTH-1:0] alloc_index,
   input  logic                       wb_valid,
   input  logic [ROB_ENTRY_WIDTH-1:0] wb_index,
   input  logic [31:0]                wb_data,
   input  logic                       wb_mispredict,
   input  logic [31:0]                wb_target,
   input  logic [ROB_ENTRY_WIDTH-1:0] q_index1,
   input  logic [ROB_ENTRY_WIDTH-1:0] q_index2,
   output logic                       q_ready1,
   output logic                       q_ready2,
   output logic [31:0]                q_data1,
   output logic [31:0]                q_data2,
   output logic                       commit_we,
   output logic [4:0]                 commit_addr,
   output logic [31:0]                commit_data,
   output logic [ROB_ENTRY_WIDTH-1:0] commit_index,
   output logic                       rollback,
   output logic [31:0]                redirect_pc,
   output logic [ROB_ENTRY_WIDTH:0]   count,
   output logic                       empty
);

   localparam int W = ROB_ENTRY_WIDTH;
   localparam logic [W:0]   FULL_COUNT = (W+1)'(ROB_ENTRY_NUM);
   localparam logic [W:0]   CNT_ONE    = 1;
   localparam logic [W-1:0] PTR_ONE    = 1;

   logic [ROB_ENTRY_NUM-1:0] busy;
   logic [ROB_ENTRY_NUM-1:0] done;
   logic [ROB_ENTRY_NUM-1:0] mispredict;
   logic [4:0]               rd_mem     [ROB_ENTRY_NUM];
   logic [31:0]              data_mem   [ROB_ENTRY_NUM];
   logic [31:0]              target_mem [ROB_ENTRY_NUM];

   logic [W-1:0] head;
   logic [W-1:0] tail;
   logic [W:0]   cnt;
   logic [W:0]   cnt_next;
   logic         retire;
   logic         retire_flush;
   logic         alloc_fire;
   logic         wb_fire;
   logic         hit1;
   logic         hit2;

   assign retire       = busy[head] && done[head];
   assign retire_flush = retire && mispredict[head];
   assign alloc_ready  = (cnt < FULL_COUNT) && !retire_flush && !rollback;
   assign alloc_fire   = alloc_valid && alloc_ready;
   assign wb_fire      = wb_valid && busy[wb_index] && !rollback;
   assign alloc_index  = tail;
   assign count        = cnt;
   assign empty        = (cnt == '0);

   assign commit_we    = retire && (rd_mem[head] != 5'd0);
   assign commit_addr  = rd_mem[head];
   assign commit_data  = data_mem[head];
   assign commit_index = head;

   // Same-cycle writeback is forwarded so a dependent op need not wait for the done bit.
   assign hit1     = wb_valid && (wb_index == q_index1);
   assign hit2     = wb_valid && (wb_index == q_index2);
   assign q_ready1 = busy[q_index1] && (done[q_index1] || hit1);
   assign q_ready2 = busy[q_index2] && (done[q_index2] || hit2);
   assign q_data1  = hit1 ? wb_data : data_mem[q_index1];
   assign q_data2  = hit2 ? wb_data : data_mem[q_index2];

   always_comb begin
      cnt_next = cnt;
      if (alloc_fire && !retire) begin
         cnt_next = cnt + CNT_ONE;
      end else if (!alloc_fire && retire) begin
         cnt_next = cnt - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy        <= '0;
         head        <= '0;
         tail        <= '0;
         cnt         <= '0;
         rollback    <= 1'b0;
         redirect_pc <= '0;
      end else begin
         rollback <= retire_flush;
         if (retire_flush) begin
            busy        <= '0;
            head        <= '0;
            tail        <= '0;
            cnt         <= '0;
            redirect_pc <= target_mem[head];
         end else begin
            if (retire) begin
               busy[head] <= 1'b0;
               head       <= head + PTR_ONE;
            end
            if (alloc_fire) begin
               busy[tail] <= 1'b1;
               tail       <= tail + PTR_ONE;
            end
            cnt <= cnt_next;
         end
      end
   end

   // Payload is qualified by busy, so it needs no reset.
   always_ff @(posedge clk) begin
      if (wb_fire) begin
         done[wb_index]       <= 1'b1;
         data_mem[wb_index]   <= wb_data;
         mispredict[wb_index] <= wb_mispredict;
         target_mem[wb_index] <= wb_target;
      end
      if (alloc_fire) begin
         done[tail]       <= 1'b0;
         mispredict[tail] <= 1'b0;
         rd_mem[tail]     <= alloc_rd;
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - randomized and directed checks of reorder_buffer against a queue model
module tb_reorder_buffer;
   localparam int N = 256;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         alloc_valid;
   logic [4:0]   alloc_rd;
   logic         alloc_ready;
   logic [W-1:0] alloc_index;
   logic         wb_valid;
   logic [W-1:0] wb_index;
   logic [31:0]  wb_data;
   logic         wb_mispredict;
   logic [31:0]  wb_target;
   logic [W-1:0] q_index1, q_index2;
   logic         q_ready1, q_ready2;
   logic [31:0]  q_data1, q_data2;
   logic         commit_we;
   logic [4:0]   commit_addr;
   logic [31:0]  commit_data;
   logic [W-1:0] commit_index;
   logic         rollback;
   logic [31:0]  redirect_pc;
   logic [W:0]   count;
   logic         empty;

   reorder_buffer #(.ROB_ENTRY_NUM(N), .ROB_ENTRY_WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_ready(alloc_ready), .alloc_index(alloc_index),
      .wb_valid(wb_valid), .wb_index(wb_index), .wb_data(wb_data),
      .wb_mispredict(wb_mispredict), .wb_target(wb_target),
      .q_index1(q_index1), .q_index2(q_index2), .q_ready1(q_ready1), .q_ready2(q_ready2),
      .q_data1(q_data1), .q_data2(q_data2),
      .commit_we(commit_we), .commit_addr(commit_addr), .commit_data(commit_data),
      .commit_index(commit_index), .rollback(rollback), .redirect_pc(redirect_pc),
      .count(count), .empty(empty)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          idx;
      logic [4:0]  rd;
      bit          done;
      logic [31:0] data;
      bit          mp;
      logic [31:0] target;
   } ent_t;

   typedef struct {
      int          idx;
      int          addr;
      logic [31:0] data;
   } com_t;

   ent_t        mq[$];
   com_t        clog[$];
   int          m_head, m_tail;
   bit          m_rb;
   logic [31:0] m_redir;
   bit          m_valid = 1'b0;
   int          tests = 0;
   int          fails = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic int find(int idx);
      for (int i = 0; i < mq.size(); i++)
         if (mq[i].idx == idx) return i;
      return -1;
   endfunction

   // Model: program-ordered queue of in-flight entries; checked and advanced once per cycle.
   always @(negedge clk) begin
      bit   ret, fl, acc, er;
      int   p;
      ent_t e;
      com_t c;
      ret = (mq.size() > 0) && mq[0].done;
      fl  = ret && mq[0].mp;
      acc = (mq.size() < N) && !fl && !m_rb;
      if (rst_n && m_valid) begin
         chk("alloc_ready", 32'(alloc_ready), 32'(acc));
         chk("alloc_index", 32'(alloc_index), m_tail);
         chk("count", 32'(count), mq.size());
         chk("empty", 32'(empty), 32'(mq.size() == 0));
         chk("commit_we", 32'(commit_we), 32'(ret && mq[0].rd != 5'd0));
         chk("commit_index", 32'(commit_index), m_head);
         if (ret) begin
            chk("commit_addr", 32'(commit_addr), 32'(mq[0].rd));
            chk("commit_data", commit_data, mq[0].data);
         end
         chk("rollback", 32'(rollback), 32'(m_rb));
         chk("redirect_pc", redirect_pc, m_redir);
         p  = find(int'(q_index1));
         er = (p >= 0) && (mq[p].done || (wb_valid && wb_index == q_index1));
         chk("q_ready1", 32'(q_ready1), 32'(er));
         if (er) chk("q_data1", q_data1, (wb_valid && wb_index == q_index1) ? wb_data : mq[p].data);
         p  = find(int'(q_index2));
         er = (p >= 0) && (mq[p].done || (wb_valid && wb_index == q_index2));
         chk("q_ready2", 32'(q_ready2), 32'(er));
         if (er) chk("q_data2", q_data2, (wb_valid && wb_index == q_index2) ? wb_data : mq[p].data);
      end
      if (rst_n && commit_we) begin
         c.idx = int'(commit_index); c.addr = int'(commit_addr); c.data = commit_data;
         clog.push_back(c);
      end
      if (!rst_n) begin
         mq.delete();
         m_head = 0; m_tail = 0; m_rb = 1'b0; m_redir = '0; m_valid = 1'b1;
      end else if (m_valid) begin
         if (ret) begin
            e = mq.pop_front();
            if (e.mp) begin
               mq.delete();
               m_head = 0; m_tail = 0; m_redir = e.target;
            end else begin
               m_head = (m_head + 1) % N;
            end
         end
         if (wb_valid && !m_rb) begin
            p = find(int'(wb_index));
            if (p >= 0) begin
               e = mq[p];
               e.done = 1'b1; e.data = wb_data; e.mp = wb_mispredict; e.target = wb_target;
               mq[p] = e;
            end
         end
         if (alloc_valid && acc) begin
            e.idx = m_tail; e.rd = alloc_rd; e.done = 1'b0; e.data = '0; e.mp = 1'b0; e.target = '0;
            mq.push_back(e);
            m_tail = (m_tail + 1) % N;
         end
         m_rb = fl;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alloc_valid = 1'b0; wb_valid = 1'b0; wb_mispredict = 1'b0;
   endtask

   task automatic reset_dut();
      idle();
      rst_n = 1'b0;
      cyc(); cyc();
      rst_n = 1'b1;
   endtask

   task automatic do_wb(int idx, logic [31:0] data, bit mp, logic [31:0] tgt);
      wb_valid = 1'b1; wb_index = W'(idx); wb_data = data; wb_mispredict = mp; wb_target = tgt;
   endtask

   task automatic alloc_n(int n);
      for (int i = 0; i < n; i++) begin
         alloc_valid = 1'b1; alloc_rd = 5'(i % 31 + 1);
         cyc();
      end
      alloc_valid = 1'b0;
   endtask

   initial begin
      idle();
      alloc_rd = '0; wb_index = '0; wb_data = '0; wb_target = '0;
      q_index1 = '0; q_index2 = '0;
      reset_dut();
      #1;
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_alloc_index", 32'(alloc_index), 32'd0);
      chk("rst_commit_we", 32'(commit_we), 32'd0);
      chk("rst_rollback", 32'(rollback), 32'd0);
      chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
      chk("rst_q_ready1", 32'(q_ready1), 32'd0);

      // out-of-order writeback, in-order commit
      cyc();
      clog.delete();
      for (int i = 0; i < 3; i++) begin
         alloc_valid = 1'b1; alloc_rd = 5'(5 + i);
         cyc();
      end
      alloc_valid = 1'b0;
      do_wb(2, 32'h33, 1'b0, 0); cyc();
      do_wb(0, 32'h11, 1'b0, 0); cyc();
      do_wb(1, 32'h22, 1'b0, 0); cyc();
      idle();
      repeat (4) cyc();
      chk("ooo_ncommits", clog.size(), 3);
      if (clog.size() == 3) begin
         chk("ooo_c0_idx", clog[0].idx, 0);  chk("ooo_c0_addr", clog[0].addr, 5); chk("ooo_c0_data", clog[0].data, 32'h11);
         chk("ooo_c1_idx", clog[1].idx, 1);  chk("ooo_c1_addr", clog[1].addr, 6); chk("ooo_c1_data", clog[1].data, 32'h22);
         chk("ooo_c2_idx", clog[2].idx, 2);  chk("ooo_c2_addr", clog[2].addr, 7); chk("ooo_c2_data", clog[2].data, 32'h33);
      end
      chk("ooo_count", 32'(count), 32'd0);

      // full, then retire index 0 and reuse it
      reset_dut();
      alloc_n(N);
      alloc_valid = 1'b1; alloc_rd = 5'd3;
      #1;
      chk("full_alloc_ready", 32'(alloc_ready), 32'd0);
      chk("full_count", 32'(count), 32'd256);
      chk("full_alloc_index", 32'(alloc_index), 32'd0);
      do_wb(0, 32'hAA, 1'b0, 0); cyc();
      wb_valid = 1'b0;
      #1;
      chk("full_retire_we", 32'(commit_we), 32'd1);
      chk("full_retire_ready", 32'(alloc_ready), 32'd0);
      cyc();
      chk("full_freed_ready", 32'(alloc_ready), 32'd1);
      chk("full_reuse_index", 32'(alloc_index), 32'd0);
      cyc();
      alloc_valid = 1'b0;
      #1;
      chk("full_again_count", 32'(count), 32'd256);
      chk("full_wrap_tail", 32'(alloc_index), 32'd1);

      // mispredict at head
      reset_dut();
      clog.delete();
      alloc_n(4);
      do_wb(0, 32'h99, 1'b1, 32'h400); cyc();
      wb_valid = 1'b0; wb_mispredict = 1'b0; alloc_valid = 1'b1;
      #1;
      chk("mp_commit_we", 32'(commit_we), 32'd1);
      chk("mp_commit_index", 32'(commit_index), 32'd0);
      chk("mp_alloc_blocked", 32'(alloc_ready), 32'd0);
      cyc();
      do_wb(1, 32'h55, 1'b0, 0);
      #1;
      chk("mp_rollback", 32'(rollback), 32'd1);
      chk("mp_redirect", redirect_pc, 32'h400);
      chk("mp_rb_empty", 32'(empty), 32'd1);
      chk("mp_rb_commit_we", 32'(commit_we), 32'd0);
      chk("mp_rb_alloc_ready", 32'(alloc_ready), 32'd0);
      cyc();
      alloc_valid = 1'b0; do_wb(2, 32'h66, 1'b0, 0);
      #1;
      chk("mp_after_rollback", 32'(rollback), 32'd0);
      chk("mp_after_empty", 32'(empty), 32'd1);
      chk("mp_after_index", 32'(alloc_index), 32'd0);
      cyc();
      idle();
      repeat (3) cyc();
      chk("mp_ncommits", clog.size(), 1);

      // lookup bypass and non-busy lookup
      reset_dut();
      alloc_n(4);
      q_index1 = 8'd3; q_index2 = 8'd7;
      do_wb(3, 32'hABCD, 1'b0, 0);
      #1;
      chk("byp_ready1", 32'(q_ready1), 32'd1);
      chk("byp_data1", q_data1, 32'hABCD);
      chk("byp_nonbusy2", 32'(q_ready2), 32'd0);
      cyc();
      wb_valid = 1'b0;
      #1;
      chk("stored_ready1", 32'(q_ready1), 32'd1);
      chk("stored_data1", q_data1, 32'hABCD);
      q_index1 = 8'd9;
      #1;
      chk("nonbusy_ready1", 32'(q_ready1), 32'd0);

      // rd=0 retires without a RAT write
      reset_dut();
      alloc_valid = 1'b1; alloc_rd = 5'd0; cyc();
      alloc_valid = 1'b0;
      do_wb(0, 32'h77, 1'b0, 0); cyc();
      wb_valid = 1'b0;
      #1;
      chk("rd0_commit_we", 32'(commit_we), 32'd0);
      chk("rd0_count", 32'(count), 32'd1);
      cyc();
      chk("rd0_head_adv", 32'(commit_index), 32'd1);
      chk("rd0_empty", 32'(empty), 32'd1);

      // randomized traffic, occasional mispredicts and resets
      reset_dut();
      for (int cy = 0; cy < 5000; cy++) begin
         rst_n         = ($urandom_range(0, 699) != 0);
         alloc_valid   = ($urandom_range(0, 9) < ((cy / 500) % 2 == 0 ? 7 : 9));
         alloc_rd      = 5'($urandom);
         wb_valid      = ($urandom_range(0, 9) < ((cy / 500) % 2 == 0 ? 6 : 2));
         if (mq.size() > 0 && $urandom_range(0, 9) < 8)
            wb_index = W'(mq[$urandom_range(0, mq.size() - 1)].idx);
         else
            wb_index = W'($urandom);
         wb_data       = $urandom;
         wb_mispredict = ($urandom_range(0, 59) == 0);
         wb_target     = $urandom;
         if (mq.size() > 0 && $urandom_range(0, 1) == 1)
            q_index1 = W'(mq[$urandom_range(0, mq.size() - 1)].idx);
         else
            q_index1 = W'($urandom);
         q_index2 = ($urandom_range(0, 3) == 0) ? wb_index : W'($urandom);
         cyc();
      end
      rst_n = 1'b1;
      idle();
      repeat (4) cyc();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
